window_accumulator: RTL and testbench
=====================================

# window_accumulator

Parametrised sliding-window summer for the temperature-sample path. It keeps the last L accepted samples in an internal ring buffer, where L is the programmable window length, 1..DEPTH. It maintains a registered running sum with a single add/subtract per sample instead of a wide adder tree. It also reports fill count and a full flag. It sits between the sample source (TN stream) and the averaging/threshold logic that consumes Tsum and N.

## Interface
Parameters:
- DATA_W, 12, sample width (unsigned)
- DEPTH, 14, maximum window length; ring storage size (≥2)
- CNT_W, $clog2(DEPTH+1), width of N and WIN_LEN
- SUM_W, DATA_W+$clog2(DEPTH+1), width of Tsum; sized so the sum never overflows

Ports:
- CLK  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- CLR  in  1  synchronous clear; also loads WIN_LEN
- WIN_LEN  in  CNT_W  requested window length, sampled only when CLR=1
- IN_VALID  in  1  TN is a valid sample this cycle
- TN  in  DATA_W  sample value
- Tsum  out  SUM_W  sum of the last N accepted samples
- N  out  CNT_W  number of samples in window, saturates at active length L
- FULL  out  1  N == L
- OUT_VALID  out  1  one-cycle pulse: Tsum/N updated
- PEAK  out  SUM_W  only with WINACC_PEAK_EN; see Configuration

## Operation
- Active length L is held in a register. RESET sets L=DEPTH. When CLR=1, L is loaded from WIN_LEN. WIN_LEN=0 or WIN_LEN>DEPTH loads DEPTH.
- The ring buffer has write pointer wp, which wraps from L-1 to 0. Entries are not cleared on reset. Stale contents are never read because the subtract path is used only when FULL.
- An accepted sample is IN_VALID=1 with CLR=0.
  - If N<L: Tsum ← Tsum+TN, N ← N+1, buf[wp] ← TN, wp advances.
  - If N==L: old ← buf[wp], Tsum ← Tsum+TN−old, buf[wp] ← TN, wp advances. N holds.
- IN_VALID=0: all state holds and OUT_VALID=0.
- CLR=1: Tsum=0, N=0, wp=0, L loaded, OUT_VALID=0. Any same-cycle sample is dropped (CLR wins).
- Arithmetic is unsigned at SUM_W. The intermediate Tsum+TN−old never underflows because old is contained in Tsum.
- FULL is combinational from the registered N and L.

## Timing
- Reset values: Tsum=0, N=0, FULL=0, OUT_VALID=0, PEAK=0, wp=0, L=DEPTH. Assertion is asynchronous; deassertion must be synchronous to CLK upstream.
- Latency is one cycle. A sample accepted at edge k is reflected in Tsum/N/FULL after edge k. OUT_VALID=1 for the cycle following edge k.
- Back-to-back samples are supported every cycle, with no stalls and no ready signal.
- RESET mid-stream discards the window immediately, with no partial update.
- Ring read and write to the same entry in one cycle: the read returns the old value (read-before-write).

## Configuration
- WINACC_PEAK_EN defined:
  - Adds the PEAK output, a registered maximum of Tsum since the last RESET/CLR.
  - PEAK updates in the same cycle as Tsum, comparing against the new Tsum value.
  - CLR and RESET zero PEAK.
- WINACC_PEAK_EN undefined: the PEAK port and its register are absent. All other behaviour is identical.

## Structure
- Package winacc_pkg holds the width helper functions (cnt_w, sum_w) and the clamp function for WIN_LEN.
- Sub-module winacc_ring holds the DEPTH×DATA_W storage, the wp register with wrap at L, and the read-before-write port.
- Top level holds the N/Tsum/L/PEAK registers and control.

## Test plan
- RESET asserted mid-clock → all outputs 0 immediately. After release, N=0, FULL=0, L=14.
- 14 samples of 100 back-to-back → Tsum 100,200…1400; N 1..14; FULL rises with the 14th. A 15th sample of 200 → Tsum=1500, N=14.
- CLR with WIN_LEN=4, then samples 1,2,3,4,5,6 → Tsum 1,3,6,10,14,18; FULL from the 4th sample.
- CLR with WIN_LEN=0 and then with WIN_LEN=15 → L=14 in both cases. 20 samples of 4095 → Tsum=57330, with no overflow at SUM_W=16.
- Sample presented in the same cycle as CLR → dropped, Tsum=0, N=0. IN_VALID gaps of 3 cycles → outputs hold and OUT_VALID stays low.
- With WINACC_PEAK_EN, WIN_LEN=2, samples 10,50,5,5 → Tsum 10,60,55,10; PEAK 10,60,60,60. After CLR, PEAK=0.

Source files
------------

// File: rtl/winacc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : winacc_pkg
// Purpose  : Shared width helpers and window-length clamp for the
//            window_accumulator slice.
// Revision : 1.0  initial release
// ============================================================================
package winacc_pkg;

  // Width needed to hold a count of 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a sum of up to depth samples of data_w bits, never overflowing.
  function automatic int sum_w(input int data_w, input int depth);
    return data_w + $clog2(depth + 1);
  endfunction

  // Out-of-range requests (zero or beyond storage) fall back to full depth.
  function automatic int clamp_len(input int req, input int depth);
    return ((req == 0) || (req > depth)) ? depth : req;
  endfunction

endpackage : winacc_pkg
`default_nettype wire

// File: rtl/winacc_ring.sv
`default_nettype none
// ============================================================================
// Module   : winacc_ring
// Purpose  : DEPTH x DATA_W sample ring with a write pointer that wraps at
//            the active window length. The read port always shows the entry
//            under the write pointer, so a same-cycle write sees the old
//            value (read-before-write).
// Revision : 1.0  initial release
// ============================================================================
module winacc_ring #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 14,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic              w_wrap;

  // Pointer is at the last slot of the active window.
  assign w_wrap  = (CNT_W'(r_wp) == (i_len - CNT_W'(1)));
  assign o_rdata = r_mem[r_wp];

  // Write pointer: cleared by reset/clear, advances on each write, wraps at L-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
    end else if (i_clr) begin
      r_wp <= '0;
    end else if (i_wr_en) begin
      r_wp <= w_wrap ? '0 : (r_wp + PTR_W'(1));
    end
  end

  // Storage is intentionally not reset; stale entries are only read once full.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wp] <= i_wdata;
    end
  end

endmodule : winacc_ring
`default_nettype wire

// File: rtl/window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : window_accumulator
// Purpose  : Sliding-window summer over the last L accepted samples, using a
//            single add/subtract per sample. Reports fill count and full flag.
//            Optional macro WINACC_PEAK_EN adds a PEAK output holding the
//            maximum Tsum since the last reset or clear.
// Revision : 1.0  initial release
// ============================================================================
module window_accumulator
  import winacc_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 14,
  parameter int CNT_W  = cnt_w(DEPTH),
  parameter int SUM_W  = sum_w(DATA_W, DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLR,
  input  logic [CNT_W-1:0]  WIN_LEN,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] TN,
  output logic [SUM_W-1:0]  Tsum,
  output logic [CNT_W-1:0]  N,
  output logic              FULL,
  output logic              OUT_VALID
`ifdef WINACC_PEAK_EN
  ,
  output logic [SUM_W-1:0]  PEAK
`endif
);

  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_n;
  logic [SUM_W-1:0]  r_sum;
  logic              r_out_valid;

  logic              w_full;
  logic              w_accept;
  logic [CNT_W-1:0]  w_len_load;
  logic [DATA_W-1:0] w_old;
  logic [SUM_W-1:0]  w_sub;
  logic [SUM_W-1:0]  w_sum_next;

  assign w_full     = (r_n == r_len);
  assign w_accept   = IN_VALID && !CLR;
  assign w_len_load = CNT_W'(clamp_len(int'(WIN_LEN), DEPTH));
  // Oldest sample is removed only once the window is full; it is part of
  // r_sum, so the subtraction cannot underflow.
  assign w_sub      = w_full ? SUM_W'(w_old) : '0;
  assign w_sum_next = r_sum + SUM_W'(TN) - w_sub;

  winacc_ring #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_ring (
    .clk     (CLK),
    .rst     (RESET),
    .i_clr   (CLR),
    .i_len   (r_len),
    .i_wr_en (w_accept),
    .i_wdata (TN),
    .o_rdata (w_old)
  );

  // Window length, fill count, running sum and update strobe.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_len       <= CNT_W'(DEPTH);
      r_n         <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else if (CLR) begin
      r_len       <= w_len_load;
      r_n         <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_sum <= w_sum_next;
        if (!w_full) begin
          r_n <= r_n + CNT_W'(1);
        end
      end
    end
  end

`ifdef WINACC_PEAK_EN
  logic [SUM_W-1:0] r_peak;

  // Track the largest running sum, compared against the value being stored.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_peak <= '0;
    end else if (CLR) begin
      r_peak <= '0;
    end else if (w_accept && (w_sum_next > r_peak)) begin
      r_peak <= w_sum_next;
    end
  end

  assign PEAK = r_peak;
`endif

  assign Tsum      = r_sum;
  assign N         = r_n;
  assign FULL      = w_full;
  assign OUT_VALID = r_out_valid;

endmodule : window_accumulator
`default_nettype wire

// File: tb/tb_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_accumulator
// Purpose  : Directed self-checking bench for window_accumulator. Peak checks
//            are included when WINACC_PEAK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_window_accumulator;

  logic        CLK;
  logic        RESET;
  logic        CLR;
  logic [3:0]  WIN_LEN;
  logic        IN_VALID;
  logic [11:0] TN;
  logic [15:0] Tsum;
  logic [3:0]  N;
  logic        FULL;
  logic        OUT_VALID;
`ifdef WINACC_PEAK_EN
  logic [15:0] PEAK;
`endif

  int n_pass  = 0;
  int n_total = 0;

  window_accumulator #(
    .DATA_W (12),
    .DEPTH  (14)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .CLR       (CLR),
    .WIN_LEN   (WIN_LEN),
    .IN_VALID  (IN_VALID),
    .TN        (TN),
    .Tsum      (Tsum),
    .N         (N),
    .FULL      (FULL),
    .OUT_VALID (OUT_VALID)
`ifdef WINACC_PEAK_EN
    ,
    .PEAK      (PEAK)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One accepted-sample cycle; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic [11:0] v);
    IN_VALID = 1'b1;
    TN       = v;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    TN       = '0;
  endtask

  task automatic do_clr(input logic [3:0] len);
    CLR     = 1'b1;
    WIN_LEN = len;
    @(posedge CLK); #1;
    CLR     = 1'b0;
    WIN_LEN = '0;
  endtask

  task automatic test_reset;
    RESET = 1'b1; CLR = 1'b0; WIN_LEN = '0; IN_VALID = 1'b0; TN = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK); #1;
    n_total++;
    if ({Tsum, N, FULL, OUT_VALID} !== {16'd0, 4'd0, 1'b0, 1'b0})
      $display("FAIL reset_state: Tsum=%0d N=%0d FULL=%0b OV=%0b, want all 0", Tsum, N, FULL, OUT_VALID);
    else n_pass++;
`ifdef WINACC_PEAK_EN
    n_total++;
    if (PEAK !== 16'd0) $display("FAIL reset_peak: PEAK=%0d want 0", PEAK);
    else n_pass++;
`endif
    send(12'd55);
    n_total++;
    if ({Tsum, N, OUT_VALID} !== {16'd55, 4'd1, 1'b1})
      $display("FAIL pre_reset_sample: Tsum=%0d N=%0d OV=%0b, want 55 1 1", Tsum, N, OUT_VALID);
    else n_pass++;
    // Assert reset between edges: outputs must clear without waiting for a clock.
    @(negedge CLK); #1 RESET = 1'b1;
    #1;
    n_total++;
    if ({Tsum, N, FULL, OUT_VALID} !== {16'd0, 4'd0, 1'b0, 1'b0})
      $display("FAIL async_reset: Tsum=%0d N=%0d FULL=%0b OV=%0b, want all 0", Tsum, N, FULL, OUT_VALID);
    else n_pass++;
    @(posedge CLK); #1 RESET = 1'b0;
    @(posedge CLK); #1;
    n_total++;
    if ({Tsum, N, FULL} !== {16'd0, 4'd0, 1'b0})
      $display("FAIL post_reset: Tsum=%0d N=%0d FULL=%0b, want 0 0 0", Tsum, N, FULL);
    else n_pass++;
  endtask

  // Default length after reset is 14.
  task automatic test_fill;
    for (int i = 0; i < 14; i++) begin
      send(12'd100);
      n_total++;
      if ({Tsum, N, FULL, OUT_VALID} !== {16'((i + 1) * 100), 4'(i + 1), (i == 13), 1'b1})
        $display("FAIL fill_%0d: Tsum=%0d N=%0d FULL=%0b OV=%0b, want %0d %0d %0b 1",
                 i, Tsum, N, FULL, OUT_VALID, (i + 1) * 100, i + 1, (i == 13));
      else n_pass++;
    end
    send(12'd200);
    n_total++;
    if ({Tsum, N, FULL} !== {16'd1500, 4'd14, 1'b1})
      $display("FAIL fill_slide: Tsum=%0d N=%0d FULL=%0b, want 1500 14 1", Tsum, N, FULL);
    else n_pass++;
  endtask

  task automatic test_winlen4;
    logic [15:0] exp_sum [6];
    exp_sum = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd14, 16'd18};
    do_clr(4'd4);
    for (int i = 0; i < 6; i++) begin
      send(12'(i + 1));
      n_total++;
      if ({Tsum, N, FULL} !== {exp_sum[i], 4'((i < 4) ? i + 1 : 4), (i >= 3)})
        $display("FAIL len4_%0d: Tsum=%0d N=%0d FULL=%0b, want %0d %0d %0b",
                 i, Tsum, N, FULL, exp_sum[i], (i < 4) ? i + 1 : 4, (i >= 3));
      else n_pass++;
    end
  endtask

  // Zero and over-range lengths both fall back to 14; max samples must not overflow.
  task automatic test_clamp;
    logic [3:0] lens [2];
    lens = '{4'd0, 4'd15};
    for (int k = 0; k < 2; k++) begin
      do_clr(lens[k]);
      for (int i = 0; i < 20; i++) begin
        send(12'd4095);
        if (i == 12) begin
          n_total++;
          if ({N, FULL} !== {4'd13, 1'b0})
            $display("FAIL clamp%0d_13: N=%0d FULL=%0b, want 13 0", lens[k], N, FULL);
          else n_pass++;
        end
        if (i == 13) begin
          n_total++;
          if ({Tsum, N, FULL} !== {16'd57330, 4'd14, 1'b1})
            $display("FAIL clamp%0d_14: Tsum=%0d N=%0d FULL=%0b, want 57330 14 1", lens[k], Tsum, N, FULL);
          else n_pass++;
        end
      end
      n_total++;
      if ({Tsum, N, FULL} !== {16'd57330, 4'd14, 1'b1})
        $display("FAIL clamp%0d_20: Tsum=%0d N=%0d FULL=%0b, want 57330 14 1", lens[k], Tsum, N, FULL);
      else n_pass++;
    end
  endtask

  task automatic test_clr_drop;
    send(12'd9);
    CLR = 1'b1; WIN_LEN = 4'd4; IN_VALID = 1'b1; TN = 12'd77;
    @(posedge CLK); #1;
    CLR = 1'b0; WIN_LEN = '0; IN_VALID = 1'b0; TN = '0;
    n_total++;
    if ({Tsum, N, OUT_VALID} !== {16'd0, 4'd0, 1'b0})
      $display("FAIL clr_drop: Tsum=%0d N=%0d OV=%0b, want 0 0 0", Tsum, N, OUT_VALID);
    else n_pass++;
  endtask

  task automatic test_gaps;
    send(12'd7);
    n_total++;
    if ({Tsum, N, OUT_VALID} !== {16'd7, 4'd1, 1'b1})
      $display("FAIL gap_first: Tsum=%0d N=%0d OV=%0b, want 7 1 1", Tsum, N, OUT_VALID);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      TN = 12'd999;
      @(posedge CLK); #1;
      n_total++;
      if ({Tsum, N, OUT_VALID} !== {16'd7, 4'd1, 1'b0})
        $display("FAIL gap_hold_%0d: Tsum=%0d N=%0d OV=%0b, want 7 1 0", i, Tsum, N, OUT_VALID);
      else n_pass++;
    end
    send(12'd8);
    n_total++;
    if ({Tsum, N, OUT_VALID} !== {16'd15, 4'd2, 1'b1})
      $display("FAIL gap_resume: Tsum=%0d N=%0d OV=%0b, want 15 2 1", Tsum, N, OUT_VALID);
    else n_pass++;
  endtask

`ifdef WINACC_PEAK_EN
  task automatic test_peak;
    logic [11:0] smp  [4];
    logic [15:0] esum [4];
    logic [15:0] epk  [4];
    smp  = '{12'd10, 12'd50, 12'd5, 12'd5};
    esum = '{16'd10, 16'd60, 16'd55, 16'd10};
    epk  = '{16'd10, 16'd60, 16'd60, 16'd60};
    do_clr(4'd2);
    for (int i = 0; i < 4; i++) begin
      send(smp[i]);
      n_total++;
      if ({Tsum, PEAK} !== {esum[i], epk[i]})
        $display("FAIL peak_%0d: Tsum=%0d PEAK=%0d, want %0d %0d", i, Tsum, PEAK, esum[i], epk[i]);
      else n_pass++;
    end
    do_clr(4'd2);
    n_total++;
    if (PEAK !== 16'd0) $display("FAIL peak_clr: PEAK=%0d want 0", PEAK);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_winlen4();
    test_clamp();
    test_clr_drop();
    test_gaps();
`ifdef WINACC_PEAK_EN
    test_peak();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_window_accumulator
`default_nettype wire
